// File: rtl/mac_seq_ctrl_if.sv
// mac_seq_ctrl_if
//   Groups the operand stream and the result stream of the MAC sequencer.
//   master: the environment side. It drives operands and result-ready.
//   slave : the sequencer side. It drives operand-ready and the result.
//   Signals:
//     op_valid / op_ready / a_in / b_in : operand pair stream (signed WIDTH)
//     res_valid / res_ready / res_data  : dot-product result stream (2*WIDTH)
interface mac_seq_ctrl_if #(
  parameter int WIDTH = 16
);
  logic               op_valid;
  logic               op_ready;
  logic [WIDTH-1:0]   a_in;
  logic [WIDTH-1:0]   b_in;
  logic               res_valid;
  logic               res_ready;
  logic [2*WIDTH-1:0] res_data;

  modport master (
    output op_valid, a_in, b_in, res_ready,
    input  op_ready, res_valid, res_data
  );

  modport slave (
    input  op_valid, a_in, b_in, res_ready,
    output op_ready, res_valid, res_data
  );
endinterface

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl
//   Sequencer for one external 2-stage saturating MAC (multiply stage, then
//   accumulate stage). It accepts a start command with vector length N and
//   clears the MAC. It then pulls N operand pairs, flushes the last product
//   into the accumulator and presents the accumulator on the result port.
//   Optional feature: define MAC_SEQ_SAT_FLAG_EN to add the sat output.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, len        command strobe (sampled only in IDLE) and vector length
//   busy, done        high outside IDLE / 1-cycle pulse on result handshake
//   bus (slave)       operand stream in, result stream out
//   mac_en, mac_clr   MAC enable / accumulator clear
//   mac_a, mac_b      MAC operands (zero whenever no pair is being issued)
//   mac_out           MAC accumulator value
//   sat               result is at a saturation limit (MAC_SEQ_SAT_FLAG_EN only)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start
// S_CLEAR  | one cycle: zero the accumulator and the stale multiply stage
// S_RUN    | accepting operand pairs, count = pairs still to come
// S_FLUSH  | one cycle: push the last product into the accumulator
// S_RESULT | MAC frozen, result offered until accepted
module mac_seq_ctrl #(
  parameter int WIDTH = 16,
  parameter int LEN_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [LEN_W-1:0]   len,
  output logic               busy,
  output logic               done,
  mac_seq_ctrl_if.slave      bus,
  output logic               mac_en,
  output logic               mac_clr,
  output logic [WIDTH-1:0]   mac_a,
  output logic [WIDTH-1:0]   mac_b,
  input  logic [2*WIDTH-1:0] mac_out
`ifdef MAC_SEQ_SAT_FLAG_EN
  ,
  output logic               sat
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_FLUSH,
    S_RESULT
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [LEN_W-1:0]   count;
  logic [LEN_W-1:0]   count_nx;
  logic               op_ready;
  logic               res_valid;
  logic [2*WIDTH-1:0] res_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      count <= '0;
    end else begin
      state <= state_nx;
      count <= count_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    count_nx  = count;
    busy      = 1'b1;
    done      = 1'b0;
    op_ready  = 1'b0;
    mac_en    = 1'b0;
    mac_clr   = 1'b0;
    mac_a     = '0;
    mac_b     = '0;
    res_valid = 1'b0;
    res_data  = '0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          count_nx = len;
          state_nx = S_CLEAR;
        end
      end
      S_CLEAR: begin
        // With zero operands, en also loads a zero product into the multiply
        // stage, so the first accumulate after this adds nothing stale.
        mac_clr  = 1'b1;
        mac_en   = 1'b1;
        state_nx = (count == '0) ? S_FLUSH : S_RUN;
      end
      S_RUN: begin
        op_ready = 1'b1;
        if (bus.op_valid) begin
          mac_en   = 1'b1;
          mac_a    = bus.a_in;
          mac_b    = bus.b_in;
          count_nx = count - LEN_W'(1);
          if (count == LEN_W'(1)) begin
            state_nx = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        mac_en   = 1'b1;
        state_nx = S_RESULT;
      end
      S_RESULT: begin
        // mac_en stays low, so mac_out cannot move while the result waits.
        res_valid = 1'b1;
        res_data  = mac_out;
        if (bus.res_ready) begin
          done     = 1'b1;
          state_nx = S_IDLE;
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  assign bus.op_ready  = op_ready;
  assign bus.res_valid = res_valid;
  assign bus.res_data  = res_data;

`ifdef MAC_SEQ_SAT_FLAG_EN
  localparam logic [2*WIDTH-1:0] MAX_POS = {1'b0, {(2*WIDTH-1){1'b1}}};
  localparam logic [2*WIDTH-1:0] MAX_NEG = {1'b1, {(2*WIDTH-1){1'b0}}};

  assign sat = (state == S_RESULT) && ((mac_out == MAX_POS) || (mac_out == MAX_NEG));
`endif

endmodule
